// File: rtl/day7_pkg.sv
// Shared constants and state encoding for the Day 7 map loader.
package day7_pkg;

    localparam int WIDTH_DEF  = 141;
    localparam int HEIGHT_DEF = 141;
    localparam int ROW_AW_DEF = 8;
    localparam int COL_AW_DEF = 8;

    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_CARET = 8'h5E;
    localparam logic [7:0] CH_S     = 8'h53;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/day7_char_class.sv
// Combinational byte classifier: splits an ASCII byte into the grid
// alphabet (cell characters, line feed, carriage return) or "bad".
module day7_char_class
    import day7_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_cell,
    output logic       cell_bit,
    output logic       is_start,
    output logic       is_lf,
    output logic       is_cr,
    output logic       is_bad
);

    assign is_start = (ch == CH_S);
    assign cell_bit = (ch == CH_CARET);
    assign is_cell  = (ch == CH_DOT) | cell_bit | is_start;
    assign is_lf    = (ch == CH_LF);
    assign is_cr    = (ch == CH_CR);
    assign is_bad   = ~(is_cell | is_lf | is_cr);

endmodule

// File: rtl/day7_map_loader.sv
// Day 7 map loader: turns a streamed ASCII grid into row bitmaps written
// one row at a time into the solver's map RAM, and reports the 'S' column,
// the number of rows written and done/error status.
module day7_map_loader
    import day7_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF,
    parameter int ROW_AW = ROW_AW_DEF,
    parameter int COL_AW = COL_AW_DEF
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              row_we,
    output logic [ROW_AW-1:0] row_addr,
    output logic [WIDTH-1:0]  row_data,
    output logic [COL_AW-1:0] start_col,
    output logic              start_found,
    output logic [ROW_AW-1:0] rows_loaded,
    output logic              done,
    output logic              error
);

    localparam logic [COL_AW-1:0] COL_FULL = COL_AW'(WIDTH);
    localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(HEIGHT - 1);

    state_t            state, state_nx;
    logic [COL_AW-1:0] col;
    logic [WIDTH-1:0]  shift_p0;

    logic is_cell, cell_bit, is_start, is_lf, is_cr, is_bad;
    logic accept;
    logic clr_load, do_shift, do_start, do_write, go_err;

    day7_char_class u_class (
        .ch       (in_data),
        .is_cell  (is_cell),
        .cell_bit (cell_bit),
        .is_start (is_start),
        .is_lf    (is_lf),
        .is_cr    (is_cr),
        .is_bad   (is_bad)
    );

    // The loader never stalls the source: it accepts every byte while loading.
    assign in_ready = (state == ST_LOAD);
    assign accept   = in_valid & in_ready;

    // Next-state and per-byte action decode.
    always_comb begin
        state_nx = state;
        clr_load = 1'b0;
        do_shift = 1'b0;
        do_start = 1'b0;
        do_write = 1'b0;
        go_err   = 1'b0;
        case (state)
            ST_LOAD: begin
                if (accept) begin
                    if (is_cell) begin
                        if (col == COL_FULL) begin
                            go_err = 1'b1;
                        end else if (is_start && start_found) begin
                            go_err = 1'b1;
                        end else begin
                            do_shift = 1'b1;
                            do_start = is_start;
                        end
                    end else if (is_lf) begin
                        if (col == COL_FULL) begin
                            do_write = 1'b1;
                            if (rows_loaded == ROW_LAST) begin
                                state_nx = ST_DONE;
                            end
                        end else if (col != '0) begin
                            go_err = 1'b1;
                        end
                    end else begin
                        // Carriage returns are dropped; anything else is malformed.
                        go_err = is_bad & ~is_cr;
                    end
                    if (go_err) begin
                        state_nx = ST_ERR;
                    end
                end
            end
            default: begin
                // IDLE, DONE and ERR all restart on start; LOAD ignores it.
                if (start) begin
                    state_nx = ST_LOAD;
                    clr_load = 1'b1;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Row shift register: new characters enter at bit 0, so after WIDTH
    // shifts column 0 sits in the MSB.
    always_ff @(posedge clk) begin
        if (clr_load) begin
            shift_p0 <= '0;
        end else if (do_shift) begin
            shift_p0 <= {shift_p0[WIDTH-2:0], cell_bit};
        end
    end

    // Counters, status flags and the registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col         <= '0;
            rows_loaded <= '0;
            start_col   <= '0;
            start_found <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            row_we      <= 1'b0;
            row_addr    <= '0;
            row_data    <= '0;
        end else begin
            row_we <= do_write;
            if (clr_load) begin
                col         <= '0;
                rows_loaded <= '0;
                start_col   <= '0;
                start_found <= 1'b0;
                done        <= 1'b0;
                error       <= 1'b0;
            end else begin
                if (do_shift) begin
                    col <= col + 1'b1;
                end
                if (do_start) begin
                    start_col   <= col;
                    start_found <= 1'b1;
                end
                if (do_write) begin
                    col         <= '0;
                    rows_loaded <= rows_loaded + 1'b1;
                    row_addr    <= rows_loaded;
                    row_data    <= shift_p0;
                end
                if (state_nx == ST_DONE && state == ST_LOAD) begin
                    done <= 1'b1;
                end
                if (go_err) begin
                    error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_day7_map_loader.sv
// Bench for day7_map_loader with a 5x3 grid. A text-level model re-parses
// everything accepted so far into lines and derives the expected outputs;
// a negedge process compares the DUT against it every cycle.
module tb_day7_map_loader;

    localparam int W   = 5;
    localparam int H   = 3;
    localparam int RAW = 2;
    localparam int CAW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           in_ready;
    logic           row_we;
    logic [RAW-1:0] row_addr;
    logic [W-1:0]   row_data;
    logic [CAW-1:0] start_col;
    logic           start_found;
    logic [RAW-1:0] rows_loaded;
    logic           done;
    logic           error;

    day7_map_loader #(.WIDTH(W), .HEIGHT(H), .ROW_AW(RAW), .COL_AW(CAW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .row_we      (row_we),
        .row_addr    (row_addr),
        .row_data    (row_data),
        .start_col   (start_col),
        .start_found (start_found),
        .rows_loaded (rows_loaded),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- text-level model ----------------
    byte unsigned sent_q[$];
    logic [W-1:0] m_rows_q[$];
    bit           m_started = 1'b0;
    bit           m_err, m_done, m_sfound;
    int           m_scol;
    bit           exp_we = 1'b0;
    bit           chk_en = 1'b0;

    // Re-parse the whole accepted text as lines of characters.
    function automatic void model_eval();
        byte unsigned cur[$];
        logic [W-1:0] r;
        m_err = 1'b0; m_done = 1'b0; m_sfound = 1'b0; m_scol = 0;
        m_rows_q.delete();
        foreach (sent_q[i]) begin
            if (m_err || m_done) break;
            if (sent_q[i] == 8'h0D) continue;
            if (sent_q[i] == 8'h0A) begin
                if (cur.size() == 0) continue;
                if (cur.size() != W) begin m_err = 1'b1; break; end
                r = '0;
                for (int k = 0; k < W; k++) r[W-1-k] = (cur[k] == 8'h5E);
                m_rows_q.push_back(r);
                cur.delete();
                if (m_rows_q.size() == H) m_done = 1'b1;
            end else if (sent_q[i] == 8'h2E || sent_q[i] == 8'h5E || sent_q[i] == 8'h53) begin
                if (cur.size() == W) begin m_err = 1'b1; break; end
                if (sent_q[i] == 8'h53) begin
                    if (m_sfound) begin m_err = 1'b1; break; end
                    m_sfound = 1'b1;
                    m_scol = cur.size();
                end
                cur.push_back(sent_q[i]);
            end else begin
                m_err = 1'b1;
                break;
            end
        end
    endfunction

    function automatic bit m_loading();
        return m_started && !m_err && !m_done;
    endfunction

    // One clock cycle of stimulus; the model advances at the same edge.
    task automatic step(input bit v, input byte unsigned b, input bit st);
        int prev;
        in_valid = v; in_data = b; start = st;
        @(posedge clk);
        prev = m_rows_q.size();
        if (st && !m_loading()) begin
            m_started = 1'b1;
            sent_q.delete();
            model_eval();
            prev = 0;
        end else if (v && m_loading()) begin
            sent_q.push_back(b);
            model_eval();
        end
        exp_we = (m_rows_q.size() > prev);
        #1;
        in_valid = 1'b0; start = 1'b0;
    endtask

    task automatic send_str(input string s, input int nbytes);
        for (int i = 0; i < nbytes && i < s.len(); i++) step(1'b1, s[i], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    // ---------------- per-cycle compare ----------------
    logic [RAW-1:0] log_addr[$];
    logic [W-1:0]   log_data[$];
    logic           log_done[$];

    always @(negedge clk) begin
        if (chk_en) begin
            if (row_we) begin
                log_addr.push_back(row_addr);
                log_data.push_back(row_data);
                log_done.push_back(done);
            end
            check("row_we", 32'(row_we), 32'(exp_we));
            if (row_we && exp_we) begin
                check("row_addr", 32'(row_addr), 32'(m_rows_q.size() - 1));
                check("row_data", 32'(row_data), 32'(m_rows_q[m_rows_q.size()-1]));
            end
            check("done", 32'(done), 32'(m_done));
            check("error", 32'(error), 32'(m_err));
            check("start_found", 32'(start_found), 32'(m_sfound));
            check("start_col", 32'(start_col), 32'(m_scol));
            check("rows_loaded", 32'(rows_loaded), 32'(m_rows_q.size()));
            check("in_ready", 32'(in_ready), 32'(m_loading()));
        end
    end

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_done.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_row_we"}, 32'(row_we), 32'd0);
        check({tag, "_row_addr"}, 32'(row_addr), 32'd0);
        check({tag, "_row_data"}, 32'(row_data), 32'd0);
        check({tag, "_start_col"}, 32'(start_col), 32'd0);
        check({tag, "_start_found"}, 32'(start_found), 32'd0);
        check({tag, "_rows_loaded"}, 32'(rows_loaded), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    string s1, s2, s3;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s1 = "..S..\n..^..\n.^.^.\n";
        s2 = "..S..\015\n..^..\015\n\015\n.^.^.\015\n";
        s3 = ".....\n.....\n.....\n";

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        model_eval();
        chk_en = 1'b1;
        idle(2);

        // 1: basic load
        clear_log();
        step(1'b0, 8'h00, 1'b1);
        send_str(s1, s1.len());
        idle(2);
        check("t1_model_row0", 32'(m_rows_q[0]), 32'(5'b00000));
        check("t1_model_row1", 32'(m_rows_q[1]), 32'(5'b00100));
        check("t1_model_row2", 32'(m_rows_q[2]), 32'(5'b01010));
        check("t1_nwrites", 32'(log_data.size()), 32'd3);
        if (log_data.size() == 3) begin
            check("t1_addr2", 32'(log_addr[2]), 32'd2);
            check("t1_data1", 32'(log_data[1]), 32'(5'b00100));
            check("t1_data2", 32'(log_data[2]), 32'(5'b01010));
            check("t1_done_with_we2", 32'(log_done[2]), 32'd1);
            check("t1_done_with_we1", 32'(log_done[1]), 32'd0);
        end
        check("t1_start_col", 32'(start_col), 32'd2);
        check("t1_start_found", 32'(start_found), 32'd1);

        // 2: CRLF line endings plus a blank line
        clear_log();
        step(1'b0, 8'h00, 1'b1);
        send_str(s2, s2.len());
        idle(2);
        check("t2_nwrites", 32'(log_data.size()), 32'd3);
        if (log_data.size() == 3) check("t2_data2", 32'(log_data[2]), 32'(5'b01010));
        check("t2_done", 32'(done), 32'd1);

        // 3: short row 1
        clear_log();
        step(1'b0, 8'h00, 1'b1);
        send_str("..S..\n..^.\n.^.^.\n", 18);
        idle(2);
        check("t3_error", 32'(error), 32'd1);
        check("t3_nwrites", 32'(log_data.size()), 32'd1);
        check("t3_in_ready", 32'(in_ready), 32'd0);

        // 4: second 'S', then an overlong row
        clear_log();
        step(1'b0, 8'h00, 1'b1);
        send_str("..S.S\n", 6);
        idle(1);
        check("t4_error", 32'(error), 32'd1);
        check("t4_nwrites", 32'(log_data.size()), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        send_str("..S...\n", 7);
        idle(1);
        check("t4_long_error", 32'(error), 32'd1);

        // 5: bad byte, then recover with a fresh load
        step(1'b0, 8'h00, 1'b1);
        send_str("..x..\n", 6);
        idle(1);
        check("t5_error", 32'(error), 32'd1);
        clear_log();
        step(1'b0, 8'h00, 1'b1);
        send_str(s1, s1.len());
        idle(2);
        check("t5_done", 32'(done), 32'd1);
        check("t5_error_clear", 32'(error), 32'd0);
        check("t5_nwrites", 32'(log_data.size()), 32'd3);

        // 6: async reset mid-load, then reload with an ignored start pulse
        step(1'b0, 8'h00, 1'b1);
        send_str(s1, 7);
        chk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        m_started = 1'b0;
        sent_q.delete();
        model_eval();
        exp_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        clear_log();
        step(1'b0, 8'h00, 1'b1);
        send_str(s1, 3);
        step(1'b0, 8'h00, 1'b1);
        for (int i = 3; i < s1.len(); i++) step(1'b1, s1[i], 1'b0);
        idle(2);
        check("t6_done", 32'(done), 32'd1);
        check("t6_nwrites", 32'(log_data.size()), 32'd3);

        // 7: no 'S' anywhere still completes
        step(1'b0, 8'h00, 1'b1);
        send_str(s3, s3.len());
        idle(2);
        check("t7_done", 32'(done), 32'd1);
        check("t7_start_found", 32'(start_found), 32'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
